updown_arbiter: RTL and testbench

Sequencer and two-port arbiter for the shared up/down counter datapath (register with clear, load and add/subtract selects). Two independent requesters each issue increment or decrement commands over a req/ack handshake. The block grants them round-robin, checks the datapath bound flags, and drives `op`/`c_clr`/`c_ld`. It sits between the requesters (e.g. entry/exit sensor front-ends) and the datapath, replacing a single-source control FSM.

---
 rtl/updown_arbiter.sv | 131 +++++++++++++
 tb/tb_updown_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/updown_arbiter.sv
// rtl/updown_arbiter.sv - round-robin two-port sequencer for the up/down counter datapath
// Optional UPDOWN_ARB_STATS_EN adds the saturating rej_cnt reject counter.
module updown_arbiter (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       clr_req,
   input  logic       req0,
   input  logic       req1,
   input  logic       dir0,
   input  logic       dir1,
   input  logic       z,
   input  logic       m,
   output logic       op,
   output logic       c_clr,
   output logic       c_ld,
   output logic       ack0,
   output logic       ack1,
   output logic       nack0,
   output logic       nack1,
   output logic       busy
`ifdef UPDOWN_ARB_STATS_EN
   ,
   output logic [7:0] rej_cnt
`endif
);

   typedef enum logic [2:0] {
      S_INIT   = 3'd0,
      S_IDLE   = 3'd1,
      S_EXEC   = 3'd2,
      S_REJECT = 3'd3,
      S_CLEAR  = 3'd4
   } state_t;

   state_t state, state_next;
   logic   g, g_next;
   logic   gd, gd_next;
   logic   last, last_next;
   logic   win;
   logic   win_dir;
   logic   allowed;

   // On a tie the requester that was not served most recently wins.
   assign win     = (req0 & req1) ? ~last : req1;
   assign win_dir = win ? dir1 : dir0;
   assign allowed = win_dir ? z : m;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_INIT;
         g     <= 1'b0;
         gd    <= 1'b0;
         last  <= 1'b1;
      end else begin
         state <= state_next;
         g     <= g_next;
         gd    <= gd_next;
         last  <= last_next;
      end
   end

   always_comb begin
      state_next = state;
      g_next     = g;
      gd_next    = gd;
      last_next  = last;
      op         = 1'b0;
      c_clr      = 1'b0;
      c_ld       = 1'b0;
      ack0       = 1'b0;
      ack1       = 1'b0;
      nack0      = 1'b0;
      nack1      = 1'b0;
      busy       = 1'b0;
      case (state)
         S_INIT: begin
            c_clr      = 1'b1;
            busy       = 1'b1;
            state_next = S_IDLE;
         end
         S_IDLE: begin
            if (clr_req) begin
               state_next = S_CLEAR;
            end else if (req0 | req1) begin
               g_next     = win;
               gd_next    = win_dir;
               state_next = allowed ? S_EXEC : S_REJECT;
            end
         end
         S_EXEC: begin
            busy       = 1'b1;
            c_ld       = 1'b1;
            op         = gd;
            ack0       = ~g;
            ack1       = g;
            last_next  = g;
            state_next = S_IDLE;
         end
         S_REJECT: begin
            busy       = 1'b1;
            nack0      = ~g;
            nack1      = g;
            last_next  = g;
            state_next = S_IDLE;
         end
         S_CLEAR: begin
            busy       = 1'b1;
            c_clr      = 1'b1;
            state_next = S_IDLE;
         end
         default: begin
            busy       = 1'b1;
            c_clr      = 1'b1;
            state_next = S_INIT;
         end
      endcase
   end

`ifdef UPDOWN_ARB_STATS_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rej_cnt <= 8'd0;
      end else if (state == S_CLEAR) begin
         rej_cnt <= 8'd0;
      end else if ((state == S_REJECT) && (rej_cnt != 8'hFF)) begin
         rej_cnt <= rej_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_updown_arbiter.sv
// tb/tb_updown_arbiter.sv - scoreboard bench for updown_arbiter against a transaction-level model
module tb_updown_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n, clr_req, req0, req1, dir0, dir1, z, m;
   logic op, c_clr, c_ld, ack0, ack1, nack0, nack1, busy;
`ifdef UPDOWN_ARB_STATS_EN
   logic [7:0] rej_cnt;
`endif

   updown_arbiter dut (
      .clk     (clk),
      .reset_n (reset_n),
      .clr_req (clr_req),
      .req0    (req0),
      .req1    (req1),
      .dir0    (dir0),
      .dir1    (dir1),
      .z       (z),
      .m       (m),
      .op      (op),
      .c_clr   (c_clr),
      .c_ld    (c_ld),
      .ack0    (ack0),
      .ack1    (ack1),
      .nack0   (nack0),
      .nack1   (nack1),
      .busy    (busy)
`ifdef UPDOWN_ARB_STATS_EN
      ,
      .rej_cnt (rej_cnt)
`endif
   );

   // Output vector order: {busy, c_clr, c_ld, op, ack0, ack1, nack0, nack1}
   localparam logic [7:0] V_IDLE  = 8'b0000_0000;
   localparam logic [7:0] V_INIT  = 8'b1100_0000;
   localparam logic [7:0] V_CLEAR = 8'b1100_0000;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] exp_q[$];
   int         rc_q[$];
   bit         mon_en = 1'b0;

   // Model: free means the arbiter will take a decision at the next edge.
   bit m_free;
   bit m_last;
   int m_rej;
   int m_pend;   // outcome being presented: 0 none/grant, 1 reject, 2 clear

   function automatic logic [7:0] outs();
      return {busy, c_clr, c_ld, op, ack0, ack1, nack0, nack1};
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   task automatic model_step();
      logic [7:0] e;
      bit w, d, ok;
      e = V_IDLE;
      if (!m_free) begin
         if (m_pend == 1 && m_rej < 255) m_rej++;
         else if (m_pend == 2) m_rej = 0;
         m_pend = 0;
         m_free = 1'b1;
      end else if (clr_req) begin
         e      = V_CLEAR;
         m_pend = 2;
         m_free = 1'b0;
      end else if (req0 || req1) begin
         w      = (req0 && req1) ? !m_last : req1;
         d      = w ? dir1 : dir0;
         ok     = d ? z : m;
         m_last = w;
         m_free = 1'b0;
         if (ok) begin
            e      = 8'b1010_0000 | (d ? 8'b0001_0000 : 8'b0) | (w ? 8'b0000_0100 : 8'b0000_1000);
            m_pend = 0;
         end else begin
            e      = 8'b1000_0000 | (w ? 8'b0000_0001 : 8'b0000_0010);
            m_pend = 1;
         end
      end
      exp_q.push_back(e);
      rc_q.push_back(m_rej);
   endtask

   task automatic drive(input bit clr, input bit r0, input bit d0, input bit r1,
                        input bit d1, input bit zz, input bit mm);
      @(negedge clk);
      clr_req = clr; req0 = r0; dir0 = d0; req1 = r1; dir1 = d1; z = zz; m = mm;
      model_step();
   endtask

   task automatic zero_inputs();
      clr_req = 0; req0 = 0; dir0 = 0; req1 = 0; dir1 = 0; z = 0; m = 0;
   endtask

   // Expects reset_n already low; checks the reset decode, then releases.
   task automatic hold_reset(input int n);
      repeat (n) begin
         @(posedge clk);
         #1 check("reset_hold", outs(), V_INIT);
      end
      @(negedge clk);
      reset_n = 1'b1;
      #1 check("init_after_release", outs(), V_INIT);
      m_free = 1'b0;
      m_last = 1'b1;
      m_rej  = 0;
      m_pend = 0;
      model_step();
      mon_en = 1'b1;
   endtask

   logic [7:0] mon_e;
   int         mon_rc;
   always begin
      @(posedge clk);
      #1;
      if (mon_en) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_underflow at %0t: got empty queue required one entry", $time);
         end else begin
            mon_e  = exp_q.pop_front();
            mon_rc = rc_q.pop_front();
            check("outputs", outs(), mon_e);
`ifdef UPDOWN_ARB_STATS_EN
            n_checks++;
            if (int'(rej_cnt) != mon_rc) begin
               n_fail++;
               $display("FAIL rej_cnt at %0t: got %0d expected %0d", $time, rej_cnt, mon_rc);
            end
`endif
         end
      end
   end

   initial begin
      zero_inputs();
      reset_n = 1'b0;
      hold_reset(3);

      // single increment, then idle
      drive(0, 1, 0, 0, 0, 1, 1);
      repeat (3) drive(0, 0, 0, 0, 0, 1, 1);

      // tie with round-robin, opposite directions
      repeat (8) drive(0, 1, 0, 1, 1, 1, 1);
      repeat (2) drive(0, 0, 0, 0, 0, 1, 1);

      // decrement at zero is rejected
      repeat (4) drive(0, 0, 0, 1, 1, 0, 1);
      repeat (2) drive(0, 0, 0, 0, 0, 1, 1);

      // clear beats a simultaneous request
      drive(1, 1, 0, 0, 0, 1, 1);
      repeat (3) drive(0, 1, 0, 0, 0, 1, 1);
      repeat (2) drive(0, 0, 0, 0, 0, 1, 1);

      // reject saturation
      repeat (620) drive(0, 0, 0, 1, 1, 0, 1);
      repeat (2) drive(0, 0, 0, 0, 0, 1, 1);
      drive(1, 0, 0, 0, 0, 1, 1);
      repeat (2) drive(0, 0, 0, 0, 0, 1, 1);

      // randomized traffic
      repeat (2000) drive(($urandom % 10) == 0, $urandom % 2, $urandom % 2, $urandom % 2,
                          $urandom % 2, ($urandom % 4) != 0, ($urandom % 4) != 0);

      // reset in the middle of an EXEC cycle
      repeat (2) drive(0, 0, 0, 0, 0, 1, 1);
      drive(0, 1, 0, 0, 0, 1, 1);
      @(posedge clk);
      #2;
      check("exec_before_reset", outs(), 8'b1010_1000);
      reset_n = 1'b0;
      mon_en  = 1'b0;
      exp_q.delete();
      rc_q.delete();
      zero_inputs();
      #1 check("reset_mid_exec", outs(), V_INIT);
      hold_reset(2);
      repeat (4) drive(0, 0, 0, 0, 0, 1, 1);
      drive(0, 0, 0, 1, 1, 1, 1);
      repeat (3) drive(0, 0, 0, 0, 0, 1, 1);

      @(posedge clk);
      #3;
      mon_en = 1'b0;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d entries left required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
